// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop controller.
// Covers the loop count, the FSM states, the decrement pulses and the counter classes.
package riscv_hwloop_pkg;

  localparam int N_HWLP = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHAIN = 2'd1,
    JUMP  = 2'd2
  } hwlp_state_e;

  typedef enum logic [1:0] {
    CNT_ZERO = 2'd0,
    CNT_ONE  = 2'd1,
    CNT_MANY = 2'd2
  } cnt_class_e;

  localparam logic [1:0] DEC_LOOP0 = 2'b01;
  localparam logic [1:0] DEC_LOOP1 = 2'b10;
  localparam logic [1:0] DEC_NONE  = 2'b00;

endpackage

// File: rtl/riscv_hwloop_match.sv
// Per-loop end-of-body detector.
// Compares the decode PC with the loop end address and classifies the remaining count.
module riscv_hwloop_match
  import riscv_hwloop_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic [31:0] end_addr,
  input  logic [31:0] counter,
  output logic        hit,
  output cnt_class_e  cnt_class
);

  // Classify the counter and detect a live loop reaching its last instruction.
  always_comb begin
    cnt_class = CNT_ZERO;
    if (counter == 32'd0) begin
      cnt_class = CNT_ZERO;
    end else if (counter == 32'd1) begin
      cnt_class = CNT_ONE;
    end else begin
      cnt_class = CNT_MANY;
    end
    hit = pc_valid && (pc == end_addr) && (cnt_class != CNT_ZERO);
  end

endmodule

// File: rtl/riscv_hwloop_controller.sv
// Two-level hardware-loop controller.
// Issues counter-decrement pulses and loop-back jumps; loop 0 is the inner loop and wins.
module riscv_hwloop_controller #(
  parameter int N_HWLP = riscv_hwloop_pkg::N_HWLP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           current_pc_i,
  input  logic                  pc_valid_i,
  input  logic [N_HWLP*32-1:0]  hwlp_start_addr_i,
  input  logic [N_HWLP*32-1:0]  hwlp_end_addr_i,
  input  logic [N_HWLP*32-1:0]  hwlp_counter_i,
  input  logic                  jump_ack_i,
  output logic                  hwlp_jump_o,
  output logic [31:0]           hwlp_targ_addr_o,
  output logic [N_HWLP-1:0]     hwlp_dec_cnt_o,
  output logic                  busy_o
);

  import riscv_hwloop_pkg::*;

  hwlp_state_e state;
  logic [N_HWLP-1:0] hit;
  cnt_class_e        cls [N_HWLP];

  // Outer-loop action deferred by one cycle when the inner loop exits at the same PC.
  logic [31:0] chain_start;
  logic        chain_many;

  for (genvar k = 0; k < N_HWLP; k++) begin : g_match
    riscv_hwloop_match u_match (
      .pc        (current_pc_i),
      .pc_valid  (pc_valid_i),
      .end_addr  (hwlp_end_addr_i[k*32 +: 32]),
      .counter   (hwlp_counter_i[k*32 +: 32]),
      .hit       (hit[k]),
      .cnt_class (cls[k])
    );
  end

  // Loop-control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      hwlp_jump_o      <= 1'b0;
      hwlp_targ_addr_o <= 32'd0;
      hwlp_dec_cnt_o   <= DEC_NONE;
      busy_o           <= 1'b0;
      chain_start      <= 32'd0;
      chain_many       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit[0]) begin
            hwlp_dec_cnt_o <= DEC_LOOP0;
            if (cls[0] == CNT_MANY) begin
              state            <= JUMP;
              busy_o           <= 1'b1;
              hwlp_jump_o      <= 1'b1;
              hwlp_targ_addr_o <= hwlp_start_addr_i[31:0];
            end else if (hit[1]) begin
              // Inner loop finished on the outer loop's end: service loop 1 next cycle.
              state       <= CHAIN;
              busy_o      <= 1'b1;
              chain_start <= hwlp_start_addr_i[63:32];
              chain_many  <= (cls[1] == CNT_MANY);
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else if (hit[1]) begin
            hwlp_dec_cnt_o <= DEC_LOOP1;
            if (cls[1] == CNT_MANY) begin
              state            <= JUMP;
              busy_o           <= 1'b1;
              hwlp_jump_o      <= 1'b1;
              hwlp_targ_addr_o <= hwlp_start_addr_i[63:32];
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            hwlp_dec_cnt_o <= DEC_NONE;
            state          <= IDLE;
            busy_o         <= 1'b0;
          end
        end
        CHAIN: begin
          hwlp_dec_cnt_o <= DEC_LOOP1;
          if (chain_many) begin
            state            <= JUMP;
            busy_o           <= 1'b1;
            hwlp_jump_o      <= 1'b1;
            hwlp_targ_addr_o <= chain_start;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        JUMP: begin
          hwlp_dec_cnt_o <= DEC_NONE;
          if (jump_ack_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            hwlp_jump_o <= 1'b0;
          end else begin
            state  <= JUMP;
            busy_o <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          busy_o         <= 1'b0;
          hwlp_jump_o    <= 1'b0;
          hwlp_dec_cnt_o <= DEC_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_hwloop_controller.sv
// Self-checking bench for riscv_hwloop_controller: directed scenarios followed by
// random traffic, compared every cycle against a queue-based action model.
module tb_riscv_hwloop_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic [63:0] sa, ea, cn;
  logic        ack;
  logic        jump;
  logic [31:0] targ;
  logic [1:0]  dec;
  logic        busy;

  always #5 clk = ~clk;

  riscv_hwloop_controller #(.N_HWLP(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .current_pc_i      (pc),
    .pc_valid_i        (pc_valid),
    .hwlp_start_addr_i (sa),
    .hwlp_end_addr_i   (ea),
    .hwlp_counter_i    (cn),
    .jump_ack_i        (ack),
    .hwlp_jump_o       (jump),
    .hwlp_targ_addr_o  (targ),
    .hwlp_dec_cnt_o    (dec),
    .busy_o            (busy)
  );

  // Each pending action is one decrement pulse, optionally with a jump to its target.
  typedef struct {
    logic [1:0]  dec;
    bit          jmp;
    logic [31:0] targ;
  } act_t;

  act_t        q[$];
  logic [1:0]  m_dec;
  bit          m_jump;
  logic [31:0] m_targ;
  bit          m_busy;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit loop_hit(int k);
    return pc_valid && (pc == ea[k*32 +: 32]) && (cn[k*32 +: 32] != 32'd0);
  endfunction

  task automatic model_edge();
    act_t a;
    logic [31:0] c0, c1;
    if (rst) begin
      q.delete();
      m_dec  = 2'b00;
      m_jump = 1'b0;
      m_targ = 32'd0;
    end else begin
      m_dec = 2'b00;
      if (m_jump) begin
        if (ack) m_jump = 1'b0;
      end else begin
        if (q.size() == 0) begin
          c0 = cn[31:0];
          c1 = cn[63:32];
          if (loop_hit(0)) begin
            a.dec = 2'b01; a.jmp = (c0 >= 32'd2); a.targ = sa[31:0];
            q.push_back(a);
            if (c0 == 32'd1 && loop_hit(1)) begin
              a.dec = 2'b10; a.jmp = (c1 >= 32'd2); a.targ = sa[63:32];
              q.push_back(a);
            end
          end else if (loop_hit(1)) begin
            a.dec = 2'b10; a.jmp = (c1 >= 32'd2); a.targ = sa[63:32];
            q.push_back(a);
          end
        end
        if (q.size() != 0) begin
          a = q.pop_front();
          m_dec = a.dec;
          if (a.jmp) begin
            m_jump = 1'b1;
            m_targ = a.targ;
          end
        end
      end
    end
    m_busy = m_jump || (q.size() != 0);
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (dec === m_dec) else begin
      miscompares++;
      $error("FAIL %s dec observed=%b expected=%b", tag, dec, m_dec);
    end
    vectors++;
    assert (jump === m_jump) else begin
      miscompares++;
      $error("FAIL %s jump observed=%b expected=%b", tag, jump, m_jump);
    end
    vectors++;
    assert (busy === m_busy) else begin
      miscompares++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, m_busy);
    end
    if (m_jump) begin
      vectors++;
      assert (targ === m_targ) else begin
        miscompares++;
        $error("FAIL %s targ observed=%h expected=%h", tag, targ, m_targ);
      end
    end
  endtask

  task automatic expect32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1'b1; pc = 32'd0; pc_valid = 1'b0; sa = 64'd0; ea = 64'd0; cn = 64'd0; ack = 1'b0;
    step("reset");
    step("reset2");
    expect32("reset_targ", targ, 32'd0);
    rst = 1'b0;
    step("idle");

    // Loop 0 iterates: jump to 0xF0, ack two cycles later.
    ea[31:0] = 32'h100; sa[31:0] = 32'hF0; cn[31:0] = 32'd3;
    pc = 32'h100; pc_valid = 1'b1;
    step("l0_many_T1");
    expect32("l0_many_targ", targ, 32'hF0);
    expect32("l0_many_dec", {30'd0, dec}, 32'd1);
    pc_valid = 1'b0;
    step("l0_many_T2");
    ack = 1'b1;
    step("l0_many_T3");
    ack = 1'b0;
    step("l0_many_T4");
    expect32("l0_many_nojump", {31'd0, jump}, 32'd0);

    // Loop 0 last iteration: single pulse, no jump, never busy.
    cn[31:0] = 32'd1; pc_valid = 1'b1;
    step("l0_one_T1");
    pc_valid = 1'b0;
    step("l0_one_T2");

    // Nested exit: inner finishes, outer jumps to 0x1C0 one cycle later.
    ea = {32'h200, 32'h200}; sa = {32'h1C0, 32'h1E0}; cn = {32'd5, 32'd1};
    pc = 32'h200; pc_valid = 1'b1;
    step("nest_T1");
    sa = {32'hDEAD0000, 32'hBEEF0000}; cn = {32'd9, 32'd9};
    step("nest_T2");
    expect32("nest_targ", targ, 32'h1C0);
    pc_valid = 1'b0;
    // Jump held while ack low, despite a new start address and a matching PC.
    sa[31:0] = 32'h12345678; pc_valid = 1'b1;
    for (int i = 0; i < 4; i++) step("jump_hold");
    expect32("jump_hold_targ", targ, 32'h1C0);
    pc_valid = 1'b0; ack = 1'b1;
    step("jump_ack");
    ack = 1'b0;
    step("after_ack");

    // Inactive loop or invalid PC: nothing happens.
    cn = 64'd0; pc_valid = 1'b1;
    step("cnt_zero");
    cn = {32'd3, 32'd3}; pc_valid = 1'b0;
    step("pc_invalid");
    ack = 1'b1;
    step("ack_idle");
    ack = 1'b0;

    // Reset right after CHAIN entry aborts the outer-loop action.
    cn = {32'd5, 32'd1}; pc_valid = 1'b1;
    step("chain_entry");
    rst = 1'b1; pc_valid = 1'b0;
    step("chain_reset");
    expect32("chain_reset_targ", targ, 32'd0);
    rst = 1'b0;
    step("chain_post1");
    step("chain_post2");

    // Random traffic on two shared end addresses.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pcs [3];
      pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
      rst      = ($urandom_range(0, 49) == 0);
      pc       = pcs[$urandom_range(0, 2)];
      pc_valid = ($urandom_range(0, 3) != 0);
      ea[31:0]  = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h200;
      ea[63:32] = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h200;
      sa = {$urandom(), $urandom()};
      for (int k = 0; k < 2; k++) begin
        cn[k*32 +: 32] = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 3));
      end
      ack = ($urandom_range(0, 2) == 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_controller.md
RISCV_HWLOOP_CONTROLLER -- requirements
Module: riscv_hwloop_controller

Interface
REQ-001 The block SHALL have the parameter N_HWLP, default 2, giving the number of hardware loops; the only supported value is 2.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port current_pc_i, input, 32 bits: PC of the instruction in the decode stage.
REQ-005 The block SHALL have the port pc_valid_i, input, 1 bit: current_pc_i is valid and the instruction advances this cycle.
REQ-006 The block SHALL have the port hwlp_start_addr_i, input, 2x32 bits: loop start addresses; loop 0 in bits [31:0].
REQ-007 The block SHALL have the port hwlp_end_addr_i, input, 2x32 bits: loop end addresses, same packing.
REQ-008 The block SHALL have the port hwlp_counter_i, input, 2x32 bits: loop counters, same packing.
REQ-009 The block SHALL have the port jump_ack_i, input, 1 bit: fetch stage accepts the pending loop jump.
REQ-010 The block SHALL have the port hwlp_jump_o, output, 1 bit: loop-back jump request to fetch.
REQ-011 The block SHALL have the port hwlp_targ_addr_o, output, 32 bits: jump target; valid while hwlp_jump_o=1.
REQ-012 The block SHALL have the port hwlp_dec_cnt_o, output, 2 bits: one-hot, one-cycle counter-decrement pulse to the hwloop registers.
REQ-013 The block SHALL have the port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 Loop k "matches" in a cycle when pc_valid_i=1, current_pc_i==hwlp_end_addr_i[k] and hwlp_counter_i[k]!=0.
REQ-015 A counter value of 0 means the loop is inactive; such a loop never matches.
REQ-016 The FSM SHALL have exactly three states: IDLE, CHAIN and JUMP.
REQ-017 Matches SHALL be evaluated only in IDLE; in CHAIN and JUMP all match inputs are ignored.
REQ-018 Loop 0 is the inner loop and has priority.
REQ-019 If loop 0 matches with counter>=2 at cycle T, then at T+1: hwlp_dec_cnt_o=2'b01, hwlp_jump_o=1, hwlp_targ_addr_o=hwlp_start_addr_i[0] as captured at T, and the state is JUMP.
REQ-020 If loop 0 matches with counter==1 and loop 1 does not match at T: hwlp_dec_cnt_o=2'b01 at T+1, no jump, and the state stays IDLE.
REQ-021 If loop 0 matches with counter==1 and loop 1 also matches at T: hwlp_dec_cnt_o=2'b01 at T+1 and the state is CHAIN; loop 1's counter and start address are captured at T.
REQ-022 In CHAIN at T+1, the next cycle (T+2) SHALL assert hwlp_dec_cnt_o=2'b10; if the captured counter is >=2, jump to the captured start address (state JUMP), else return to IDLE.
REQ-023 If only loop 1 matches at T, it SHALL follow the REQ-019/REQ-020 rules with the pulse 2'b10 and start address [1].
REQ-024 hwlp_dec_cnt_o SHALL never have more than one bit set and SHALL never be high for two consecutive cycles for the same event.
REQ-025 In JUMP, hwlp_jump_o and hwlp_targ_addr_o SHALL hold stable until jump_ack_i=1 is sampled; the state is IDLE on the following cycle, with hwlp_jump_o=0.
REQ-026 jump_ack_i SHALL be ignored outside JUMP.
REQ-027 Register writes that change the address or counter inputs during CHAIN or JUMP SHALL NOT alter the captured target or the pending actions.
REQ-028 Address comparisons SHALL be 32-bit equality; counter tests SHALL be unsigned (==0, ==1, >=2) with no wrap-around.

Reset
REQ-029 With rst=1 at a rising clk edge: state=IDLE, hwlp_jump_o=0, hwlp_targ_addr_o=0, hwlp_dec_cnt_o=2'b00, busy_o=0, all captured registers cleared.
REQ-030 Reset asserted in CHAIN or JUMP SHALL abort the operation: no further decrement pulse and no jump after reset.

Structure
REQ-031 Package riscv_hwloop_pkg SHALL hold N_HWLP, the state enum (IDLE, CHAIN, JUMP) and the 2'b01/2'b10 decrement constants.
REQ-032 One sub-module, riscv_hwloop_match, SHALL be instantiated per loop; it compares the PC against the end address and classifies the counter as zero, one or at-least-two.
REQ-033 All outputs SHALL be driven from registers (no combinational input-to-output path).

Verification
REQ-034 Scenario: loop 0 end=0x100, start=0xF0, counter=3; pc=0x100 valid at T -> at T+1 dec=01, jump=1, targ=0xF0; ack at T+3 -> jump=0 at T+4.
REQ-035 Scenario: loop 0 counter=1, pc matches -> dec=01 for one cycle, jump stays 0, busy_o stays 0.
REQ-036 Scenario: nested loops, both end=0x200, cnt0=1, cnt1=5, start1=0x1C0 -> T+1 dec=01; T+2 dec=10, jump=1, targ=0x1C0.
REQ-037 Scenario: counter=0 with pc==end, or pc_valid_i=0 with pc==end -> no dec pulse and no jump.
REQ-038 Scenario: in JUMP, change start address and present a matching pc with ack held low for 4 cycles -> target unchanged, no new dec pulse.
REQ-039 Scenario: rst=1 in the cycle after a CHAIN entry -> no dec=10 pulse, state IDLE, all outputs zero.
